// File: rtl/canon_sequencer.sv
// Canon sequencer: beat divider, note ROM, square-wave tone generator and PWM output.
// Define CANON_ENVELOPE_EN to add a per-crotchet decaying volume envelope on the PWM.
module canon_sequencer #(
    parameter int CROTCHET_CYCLES = 12587500,
    parameter int SONG_LEN        = 128,
    parameter int ENV_SHIFT       = 14
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run,
    output logic [6:0]  crotchet,
    output logic        crotchet_pulse,
    output logic [15:0] note_half,
    output logic        pwm
);

    localparam int DIV_W = (CROTCHET_CYCLES > 1) ? $clog2(CROTCHET_CYCLES) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CROTCHET_CYCLES - 1);
    localparam logic [6:0] CROT_LAST = 7'(SONG_LEN - 1);

    // Half-periods at 25.175 MHz: D5 C#5 B4 A4 G4 F#4 G4 A4 F#4 D4 E4 F#4 G4 A4 B4 C#5
    localparam logic [15:0] MELODY [16] = '{
        16'd21432, 16'd22706, 16'd25487, 16'd28608,
        16'd32111, 16'd34021, 16'd32111, 16'd28608,
        16'd34021, 16'd42864, 16'd38187, 16'd34021,
        16'd32111, 16'd28608, 16'd25487, 16'd22706
    };

    // NOTE: the ROM is pure constant decode, so it has no storage to reset.
    function automatic logic [15:0] rom_lookup(input logic [6:0] idx);
        case (idx)
            7'd0:    rom_lookup = 16'd28608;
            7'd1:    rom_lookup = 16'd0;
            default: rom_lookup = MELODY[4'(idx - 7'd2)];
        endcase
    endfunction

    logic [DIV_W-1:0] div_cnt;
    logic             armed;
    logic [15:0]      tone_cnt;
    logic             square;
    logic             advance;

    // A new crotchet begins either at the very first running cycle or at divider terminal count.
    assign advance = run && (armed || div_cnt == DIV_LAST);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt        <= '0;
            crotchet       <= '0;
            crotchet_pulse <= 1'b0;
            armed          <= 1'b1;
        end else begin
            crotchet_pulse <= advance;
            if (advance) begin
                div_cnt  <= '0;
                armed    <= 1'b0;
                crotchet <= (armed || crotchet == CROT_LAST) ? 7'd0 : crotchet + 7'd1;
            end else if (run) begin
                div_cnt <= div_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            note_half <= '0;
            tone_cnt  <= '0;
            square    <= 1'b0;
        end else if (crotchet_pulse) begin
            note_half <= rom_lookup(crotchet);
            tone_cnt  <= '0;
            square    <= 1'b0;
        end else if (run) begin
            if (note_half == 16'd0) begin
                tone_cnt <= '0;
                square   <= 1'b0;
            end else if (tone_cnt == note_half - 16'd1) begin
                tone_cnt <= '0;
                square   <= ~square;
            end else begin
                tone_cnt <= tone_cnt + 16'd1;
            end
        end
    end

`ifdef CANON_ENVELOPE_EN
    logic [7:0]           carrier;
    logic [7:0]           volume;
    logic [ENV_SHIFT-1:0] env_cnt;

    // Volume restarts at full scale with each crotchet and decays one step per prescaler wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            carrier <= '0;
            volume  <= '0;
            env_cnt <= '0;
            pwm     <= 1'b0;
        end else begin
            carrier <= carrier + 8'd1;
            pwm     <= run && square && (carrier < volume);
            if (advance) begin
                volume  <= 8'd255;
                env_cnt <= '0;
            end else if (run) begin
                env_cnt <= env_cnt + 1'b1;
                if (&env_cnt && volume != 8'd0) begin
                    volume <= volume - 8'd1;
                end
            end
        end
    end
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm <= 1'b0;
        end else begin
            pwm <= run && square;
        end
    end
`endif

endmodule
